// File: rtl/slon5_pkg.sv
// Shared types and constants for the slon5 display scan controller.
package slon5_pkg;

    // Number of multiplexed digits on the slon5 board; sets the width of Dnum_t.
    localparam int SLON5_DIGITS = 4;

    // Segment bus: a..g in [6:0], decimal point in [7].
    typedef logic [7:0] Dout_t;

    // One-hot digit select bus.
    typedef logic [SLON5_DIGITS-1:0] Dnum_t;

    // Scan FSM: each digit slot is a blank gap followed by the lit period.
    typedef enum logic {
        SC_BLANK,
        SC_SHOW
    } scan_state_t;

    // Active-high a..g patterns for hex digits 0..F (bit 0 = a, bit 6 = g).
    localparam logic [6:0] SEG_HEX [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F,
        7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C,
        7'h39, 7'h5E, 7'h79, 7'h71
    };

endpackage

// File: rtl/slon5_hex7.sv
// Hex nibble plus decimal point to active-high 7-segment pattern.
module slon5_hex7
    import slon5_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       dp,
    output Dout_t      seg
);

    // Pure table lookup; output polarity is the caller's concern.
    assign seg = {dp, SEG_HEX[nibble]};

endmodule

// File: rtl/slon5_scan_ctrl.sv
// Multiplexed 7-segment scan controller: slot timing with anti-ghost blank,
// PWM brightness, hex decode, and frame-aligned double-buffered display data.
module slon5_scan_ctrl
    import slon5_pkg::*;
#(
    parameter int DIGITS      = 4,
    parameter int SLOT        = 50000,
    parameter int BLANK       = 16,
    parameter bit SEG_ACT_LOW = 1'b1,
    parameter bit DIG_ACT_LOW = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [4*DIGITS-1:0]   load_data,
    input  logic [DIGITS-1:0]     load_dp,
    input  logic                  load_valid,
    output logic                  load_ready,
    input  logic [3:0]            bright,
    output logic                  frame_start,
    output Dout_t                 dout,
    output logic [DIGITS-1:0]     dnum
);

    localparam int CNT_W = $clog2(SLOT);
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(SLOT - 1);
    localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DIGITS - 1);

    // Deasserted levels of the output pins.
    localparam Dout_t             SEG_OFF = {8{SEG_ACT_LOW}};
    localparam logic [DIGITS-1:0] DIG_OFF = {DIGITS{DIG_ACT_LOW}};

    scan_state_t          state_q, state_d;
    logic [CNT_W-1:0]     slot_cnt_q, slot_cnt_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [3:0]           pwm_q, pwm_d;
    logic [3:0]           bright_s_q;
    logic                 digit_on;

    logic [4*DIGITS-1:0]  active_data_q, pend_data_q;
    logic [DIGITS-1:0]    active_dp_q, pend_dp_q;
    logic                 pend_full_q;

    logic                 slot_wrap, frame_wrap, accept, commit;
    logic [3:0]           cur_nibble;
    logic                 cur_dp;
    Dout_t                cur_seg;
    logic [DIGITS-1:0]    sel_onehot;

    Dout_t                dout_p1;
    logic [DIGITS-1:0]    dnum_p1;
    logic                 frame_start_p1;

    assign slot_wrap  = (slot_cnt_q == CNT_LAST);
    assign frame_wrap = slot_wrap && (idx_q == IDX_LAST);
    assign accept     = load_valid && !pend_full_q;
    assign commit     = frame_wrap && pend_full_q;
    assign load_ready = ~pend_full_q;

    assign cur_nibble = active_data_q[{idx_q, 2'b00} +: 4];
    assign cur_dp     = active_dp_q[idx_q];
    assign sel_onehot = DIGITS'(1) << idx_q;

    slon5_hex7 u_hex7 (
        .nibble (cur_nibble),
        .dp     (cur_dp),
        .seg    (cur_seg)
    );

    // Next slot position, FSM transition and whether the current digit is lit.
    always_comb begin
        slot_cnt_d = slot_wrap ? '0 : slot_cnt_q + 1'b1;
        idx_d      = idx_q;
        if (slot_wrap) begin
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
        end
        state_d  = state_q;
        pwm_d    = '0;
        digit_on = 1'b0;
        case (state_q)
            SC_BLANK: begin
                if (slot_cnt_d >= CNT_BLANK) begin
                    state_d = SC_SHOW;
                end
            end
            SC_SHOW: begin
                // 15 is full-on; otherwise lit for the first bright_s of every 16 clocks.
                digit_on = (bright_s_q == 4'hF) || (pwm_q < bright_s_q);
                if (slot_wrap) begin
                    state_d = SC_BLANK;
                end else begin
                    pwm_d = pwm_q + 1'b1;
                end
            end
            default: state_d = SC_BLANK;
        endcase
    end

    // Slot timing, FSM state, PWM counter and per-slot brightness sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= SC_BLANK;
            slot_cnt_q <= '0;
            idx_q      <= '0;
            pwm_q      <= '0;
            bright_s_q <= '0;
        end else begin
            state_q    <= state_d;
            slot_cnt_q <= slot_cnt_d;
            idx_q      <= idx_d;
            pwm_q      <= pwm_d;
            if (slot_cnt_q == '0) begin
                bright_s_q <= bright;
            end
        end
    end

    // Pending/active double buffer; only swaps at the frame boundary so a frame is never torn.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active_data_q <= '0;
            active_dp_q   <= '0;
            pend_data_q   <= '0;
            pend_dp_q     <= '0;
            pend_full_q   <= 1'b0;
        end else if (commit) begin
            active_data_q <= pend_data_q;
            active_dp_q   <= pend_dp_q;
            pend_full_q   <= 1'b0;
        end else if (accept) begin
            pend_data_q   <= load_data;
            pend_dp_q     <= load_dp;
            pend_full_q   <= 1'b1;
        end
    end

    // Output register stage with pin polarity applied.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout_p1        <= SEG_OFF;
            dnum_p1        <= DIG_OFF;
            frame_start_p1 <= 1'b0;
        end else begin
            dout_p1        <= digit_on ? (cur_seg ^ SEG_OFF) : SEG_OFF;
            dnum_p1        <= digit_on ? (sel_onehot ^ DIG_OFF) : DIG_OFF;
            frame_start_p1 <= frame_wrap;
        end
    end

    assign dout        = dout_p1;
    assign dnum        = dnum_p1;
    assign frame_start = frame_start_p1;

endmodule

// File: tb/tb_slon5_scan_ctrl.sv
// Bench for slon5_scan_ctrl: per-cycle reference model on a short-slot instance,
// PWM duty measurement on a long-slot instance.
module tb_slon5_scan_ctrl;

    localparam int DIGITS = 4;
    localparam int SLOT   = 8;
    localparam int BLANK  = 2;
    localparam int FRAME  = DIGITS * SLOT;
    localparam int SLOT_L  = 40;
    localparam int FRAME_L = DIGITS * SLOT_L;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [15:0] load_data = '0;
    logic [3:0]  load_dp = '0;
    logic        load_valid = 1'b0;
    logic [3:0]  bright = 4'hF;

    logic        load_ready, frame_start;
    logic [7:0]  dout;
    logic [3:0]  dnum;
    logic        load_ready_l, frame_start_l;
    logic [7:0]  dout_l;
    logic [3:0]  dnum_l;

    int n_asserts = 0;
    int n_fail    = 0;

    // Standard active-high a..g patterns, digits 0..F.
    logic [6:0] hex_tab [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    // Reference model state: clocks since reset release, buffers, latched brightness.
    int          m_t;
    logic [3:0]  m_bs;
    logic [15:0] m_act, m_pend;
    logic [3:0]  m_act_dp, m_pend_dp;
    bit          m_full;

    always #5 clk = ~clk;

    slon5_scan_ctrl #(
        .DIGITS(DIGITS), .SLOT(SLOT), .BLANK(BLANK), .SEG_ACT_LOW(1'b1), .DIG_ACT_LOW(1'b1)
    ) u_dut (
        .clk(clk), .rst_n(rst_n), .load_data(load_data), .load_dp(load_dp),
        .load_valid(load_valid), .load_ready(load_ready), .bright(bright),
        .frame_start(frame_start), .dout(dout), .dnum(dnum)
    );

    slon5_scan_ctrl #(
        .DIGITS(DIGITS), .SLOT(SLOT_L), .BLANK(BLANK), .SEG_ACT_LOW(1'b1), .DIG_ACT_LOW(1'b1)
    ) u_dut_l (
        .clk(clk), .rst_n(rst_n), .load_data(load_data), .load_dp(load_dp),
        .load_valid(load_valid), .load_ready(load_ready_l), .bright(bright),
        .frame_start(frame_start_l), .dout(dout_l), .dnum(dnum_l)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_t = 0; m_bs = '0; m_act = '0; m_pend = '0;
        m_act_dp = '0; m_pend_dp = '0; m_full = 1'b0;
    endtask

    // Lit clocks per frame of the long-slot instance for a constant brightness.
    function automatic int lit_per_frame(input int b);
        int show;
        show = SLOT_L - BLANK;
        if (b == 15) return DIGITS * show;
        return DIGITS * (b * (show / 16) + ((show % 16) < b ? (show % 16) : b));
    endfunction

    // One clock: predict the registered outputs from the model, advance it, compare.
    task automatic tick();
        int cnt, idx;
        bit on;
        logic [7:0] e_dout;
        logic [3:0] e_dnum;
        logic [3:0] one;
        logic e_fs;
        cnt = m_t % SLOT;
        idx = (m_t / SLOT) % DIGITS;
        on = (cnt >= BLANK) && ((m_bs == 4'd15) || (((cnt - BLANK) % 16) < int'(m_bs)));
        one = 4'b0001;
        e_dout = on ? ~{m_act_dp[idx], hex_tab[m_act[idx*4 +: 4]]} : 8'hFF;
        e_dnum = on ? ~(one << idx) : 4'hF;
        e_fs = ((m_t + 1) % FRAME) == 0;
        if (cnt == 0) m_bs = bright;
        if (e_fs && m_full) begin
            m_act = m_pend; m_act_dp = m_pend_dp; m_full = 1'b0;
        end else if (load_valid && !m_full) begin
            m_pend = load_data; m_pend_dp = load_dp; m_full = 1'b1;
        end
        m_t++;
        @(posedge clk);
        #1;
        check("dout", {24'd0, dout}, {24'd0, e_dout});
        check("dnum", {28'd0, dnum}, {28'd0, e_dnum});
        check("load_ready", {31'd0, load_ready}, {31'd0, !m_full});
        check("frame_start", {31'd0, frame_start}, {31'd0, e_fs});
    endtask

    // Advance until the model sits at (digit d, slot count c).
    task automatic run_until(input int d, input int c);
        int k;
        k = 0;
        while (!(((m_t % SLOT) == c) && (((m_t / SLOT) % DIGITS) == d)) && k < 2 * FRAME) begin
            tick();
            k++;
        end
    endtask

    task automatic measure_long(input int b, input string tag);
        int lit, fs;
        bright = 4'(b);
        repeat (2 * FRAME_L) tick();
        lit = 0; fs = 0;
        repeat (FRAME_L) begin
            tick();
            if (dnum_l != 4'hF) lit++;
            if (frame_start_l) fs++;
        end
        check(tag, lit, lit_per_frame(b));
        check("long_fs_count", fs, 1);
    endtask

    initial begin
        int last_fs, lit;
        logic [3:0] exp_sel;

        // Reset state
        #2 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_dout", {24'd0, dout}, 32'hFF);
        check("rst_dnum", {28'd0, dnum}, 32'hF);
        check("rst_ready", {31'd0, load_ready}, 32'd1);
        check("rst_fs", {31'd0, frame_start}, 32'd0);
        check("rst_ready_l", {31'd0, load_ready_l}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();

        // Idle at full brightness: digit 2 shows '0', frames every 32 clocks
        bright = 4'hF;
        run_until(2, BLANK + 1);
        check("idle_d2_dnum", {28'd0, dnum}, 32'hB);
        check("idle_d2_dout", {24'd0, dout}, 32'hC0);
        last_fs = -1;
        repeat (3 * FRAME) begin
            tick();
            if (frame_start) begin
                if (last_fs >= 0) check("fs_period", m_t - last_fs, FRAME);
                last_fs = m_t;
            end
        end

        // Blank gap then digit enable, in digit order 0,1,2,3,0
        run_until(0, BLANK + 1);
        check("seq_d0", {28'd0, dnum}, 32'hE);
        for (int d = 1; d <= DIGITS; d++) begin
            run_until(d % DIGITS, 1);
            check("blank0", {28'd0, dnum}, 32'hF);
            tick();
            check("blank1", {28'd0, dnum}, 32'hF);
            tick();
            exp_sel = 4'b0001 << (d % DIGITS);
            check("seq_on", {28'd0, dnum}, {28'd0, ~exp_sel});
        end

        // Mid-frame load commits at the next frame boundary
        run_until(1, 4);
        load_data = 16'h1234; load_dp = 4'b0001; load_valid = 1'b1;
        tick();
        load_valid = 1'b0; load_data = 16'h0; load_dp = 4'h0;
        check("load_ready_drop", {31'd0, load_ready}, 32'd0);
        run_until(3, BLANK + 1);
        check("pre_commit_d3", {24'd0, dout}, 32'hC0);
        run_until(0, 0);
        check("commit_fs", {31'd0, frame_start}, 32'd1);
        check("commit_ready", {31'd0, load_ready}, 32'd1);
        run_until(0, BLANK + 1);
        check("d0_4dp", {24'd0, dout}, 32'h19);
        run_until(3, BLANK + 1);
        check("d3_1", {24'd0, dout}, 32'hF9);

        // Offer while full is held off until the buffer empties
        run_until(1, 3);
        load_data = 16'h5678; load_dp = 4'h0; load_valid = 1'b1;
        tick();
        load_data = 16'hABCD; load_dp = 4'b1010;
        tick();
        check("held_not_ready", {31'd0, load_ready}, 32'd0);
        for (int i = 0; i < 2 * FRAME && !load_ready; i++) tick();
        check("ready_rises", {31'd0, load_ready}, 32'd1);
        tick();
        load_valid = 1'b0;
        check("held_accepted", {31'd0, load_ready}, 32'd0);
        run_until(0, 0);
        run_until(1, BLANK + 1);
        check("d1_Cdp", {24'd0, dout}, 32'h46);

        // Brightness 0: nothing lit for a whole frame
        bright = 4'h0;
        repeat (FRAME + SLOT) tick();
        lit = 0;
        repeat (FRAME) begin
            tick();
            if (dnum != 4'hF) lit++;
        end
        check("bright0_lit", lit, 0);

        // PWM duty on the long-slot instance
        measure_long(4, "pwm4_lit");
        measure_long(0, "pwm0_lit");
        measure_long(15, "pwm15_lit");

        // Randomized loads and brightness
        for (int i = 0; i < 1500; i++) begin
            load_valid = ($urandom_range(0, 3) == 0);
            load_data  = 16'($urandom);
            load_dp    = 4'($urandom);
            if ((i % 40) == 0) bright = 4'($urandom);
            tick();
        end
        load_valid = 1'b0;

        // Asynchronous reset mid-SHOW with pending data
        bright = 4'hF;
        repeat (FRAME) tick();
        load_data = 16'hFFFF; load_dp = 4'hF; load_valid = 1'b1;
        for (int i = 0; i < 2 * FRAME && load_ready; i++) tick();
        load_valid = 1'b0;
        check("pre_rst_full", {31'd0, load_ready}, 32'd0);
        run_until(2, BLANK + 3);
        check("pre_rst_on", {28'd0, dnum}, 32'hB);
        #3 rst_n = 1'b0;
        #2;
        check("arst_dout", {24'd0, dout}, 32'hFF);
        check("arst_dnum", {28'd0, dnum}, 32'hF);
        check("arst_ready", {31'd0, load_ready}, 32'd1);
        check("arst_fs", {31'd0, frame_start}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        run_until(0, BLANK + 1);
        check("post_rst_d0_dnum", {28'd0, dnum}, 32'hE);
        check("post_rst_d0_dout", {24'd0, dout}, 32'hC0);
        repeat (2 * FRAME) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule

// File: doc/slon5_scan_ctrl.md
Name: slon5_scan_ctrl

Overview:
Scan controller that sequences the slon5 multiplexed 7-segment display: time-slots one digit at a time, inserts an anti-ghosting blank, applies PWM brightness and decodes hex nibbles to segments. Display data is loaded through a valid/ready handshake into a pending buffer and committed only at frame boundaries, so a frame never shows torn data. Sits between the slon5 datapath (producer of digit values) and the dout/dnum pins.

Parameters:
DIGITS, 4, number of multiplexed digits; equals width of Dnum_t
SLOT, 50000, clocks per digit slot (blank + show); must be > BLANK+16
BLANK, 16, clocks at the start of each slot with all digits off
SEG_ACT_LOW, 1, 1 = segment lines active-low on dout
DIG_ACT_LOW, 1, 1 = digit-select lines active-low on dnum

Ports:
clk  in  1  system clock
rst_n  in  1  reset, asynchronous, active-low
load_data  in  4*DIGITS  hex nibble per digit, digit 0 in bits [3:0]
load_dp  in  DIGITS  decimal point per digit
load_valid  in  1  producer offers load_data/load_dp
load_ready  out  1  pending buffer empty, transfer accepted when valid&&ready
bright  in  4  brightness 0..15, sampled at each slot start
frame_start  out  1  one-clock pulse when digit 0's slot begins
dout  out  8 (Dout_t)  segments a..g in [6:0], dp in [7]
dnum  out  DIGITS (Dnum_t)  one-hot digit select

Behaviour:
- Reset (async, rst_n=0): FSM=BLANK, digit index=0, slot counter=0, pwm counter=0, active and pending buffers=0, pending_full=0. Outputs: dout=all segments inactive, dnum=all digits inactive, load_ready=1, frame_start=0. Reset mid-transfer discards pending data.
- Slot counter runs 0..SLOT-1 and wraps; on wrap the digit index increments, wrapping DIGITS-1 -> 0.
- FSM: BLANK (slot cnt < BLANK) -> SHOW (BLANK <= cnt < SLOT) -> BLANK of next digit. No other states.
- BLANK: dnum all inactive, dout all inactive.
- SHOW: 4-bit pwm counter increments every clock (cleared at SHOW entry). Digit on when pwm_cnt < bright_s, or bright_s==15 (full on). bright_s==0: digit never on. bright_s is the bright value latched at slot counter 0.
- When on: dnum one-hot at current index; dout = hex decode of active nibble (0-F, standard a..g patterns) with dp from active_dp.
- Polarity is applied at the output registers per SEG_ACT_LOW/DIG_ACT_LOW; "inactive" means the deasserted level.
- Output latency: dout/dnum are registered, one clock after the internal FSM/counter state that produces them.
- Handshake: load_ready = !pending_full (registered). valid&&ready -> pending <= load_data/load_dp, pending_full <= 1, so load_ready drops next clock. load_data stable not required after the accept edge.
- Commit: at frame boundary (slot cnt wraps with index DIGITS-1 -> 0), if pending_full then active <= pending, pending_full <= 0; load_ready rises the clock after the commit.
- Simultaneous accept and commit in the same clock: commit uses old pending contents (only possible if pending_full=0, so nothing is committed); the new data waits for the next frame boundary.
- frame_start: asserted for exactly one clock at slot counter 0 of digit 0, aligned with the first cycle in which active holds the committed data.
- Without new loads, active holds indefinitely. Frame period = DIGITS*SLOT clocks.

Decomposition:
- slon5_pkg: Dout_t, Dnum_t, hex-to-segment constant table SEG_HEX[16], scan_state_t enum {SC_BLANK, SC_SHOW}.
- Sub-module slon5_hex7: combinational nibble+dp -> Dout_t, active-high; polarity is applied in the controller.

Test Plan:
(Bench parameters: DIGITS=4, SLOT=8, BLANK=2, both polarities active-low.)
- Reset then idle, bright=15 -> load_ready=1, frame_start every 32 clks; during SHOW of digit 2, dnum=4'b1011 and dout=~8'h3F (digit 0, dp off).
- Load 16'h1234, dp=4'b0001 mid-frame -> load_ready=0 next clk; data unchanged until next frame_start. Then digit0 shows '4' with dp (dout=~8'hE6), digit3 shows '1' (~8'h06); load_ready=1 one clk after commit.
- Second load_valid while pending_full -> not accepted (load_ready=0); the held value transfers after load_ready rises.
- bright=0 -> dnum all inactive for a full frame; bright=4 (SLOT raised to 40) -> digit on for exactly 4 of every 16 SHOW clocks.
- Each slot starts with 2 clks of dnum=4'hF (blank) before the digit is enabled; the digit sequence is 0,1,2,3,0.
- rst_n low asynchronously mid-SHOW with pending_full=1 -> outputs go inactive immediately. After release: active=0, load_ready=1, index=0.
